cart_rom_ctrl: RTL

//  Sequences cartridge ROM loading and shares the ROM read port once loaded.

---
 rtl/cart_rom_ctrl_pkg.sv | 29 ++
 rtl/cart_rom_ctrl_if.sv | 46 ++++
 rtl/cart_rom_ctrl_arb.sv | 62 ++++++
 rtl/cart_rom_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cart_rom_ctrl_pkg.sv
// Shared types and constants for the cartridge ROM controller.
// Latency: none; this file holds only declarations and a pure helper function.
// Backpressure: none.
package scv_cart_pkg;

  localparam int          CART_ADDR_W   = 17;
  localparam int          CART_MIN_LOG2 = 13;
  localparam logic [7:0]  CART_PAD_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_PAD,
    ST_SETTLE,
    ST_HOLD,
    ST_RUN
  } cart_state_t;

  // Last address of the smallest power-of-two image (at least 2^CART_MIN_LOG2
  // bytes) that contains byte address a. Smearing the top set bit downward
  // gives 2^k-1 with 2^k > a.
  function automatic logic [23:0] pad_end_of(input logic [23:0] a);
    logic [23:0] m;
    m = a;
    for (int i = 0; i < 5; i++) m = m | (m >> (1 << i));
    return m | 24'((1 << CART_MIN_LOG2) - 1);
  endfunction

endpackage

// File: rtl/cart_rom_ctrl_if.sv
// Bundle of host download, ROM init, CPU, debug, ROM read and status signals.
// Latency: wires only.
// Backpressure: DL_WAIT stalls the host; DBG_REQ is held until DBG_ACK.
// Modports: slave = the controller, master = the surrounding system.
interface cart_rom_ctrl_if
  import scv_cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
);
  logic              DL_ACTIVE;
  logic              DL_WR;
  logic [23:0]       DL_ADDR;
  logic [7:0]        DL_DATA;
  logic              DL_WAIT;
  logic              INIT_SEL;
  logic [ADDR_W-1:0] INIT_ADDR;
  logic [7:0]        INIT_DATA;
  logic              INIT_VALID;
  logic [4:0]        SIZE_LOG2;
  logic [ADDR_W-1:0] CPU_A;
  logic              CPU_CSB;
  logic [7:0]        CPU_DB;
  logic              DBG_REQ;
  logic [ADDR_W-1:0] DBG_A;
  logic              DBG_ACK;
  logic [7:0]        DBG_DB;
  logic [ADDR_W-1:0] ROM_A;
  logic              ROM_CSB;
  logic [7:0]        ROM_DB;
  logic              SYS_RESET;
  logic              OVERSIZE;

  modport slave (
    input  DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA, SIZE_LOG2,
           CPU_A, CPU_CSB, DBG_REQ, DBG_A, ROM_DB,
    output DL_WAIT, INIT_SEL, INIT_ADDR, INIT_DATA, INIT_VALID,
           CPU_DB, DBG_ACK, DBG_DB, ROM_A, ROM_CSB, SYS_RESET, OVERSIZE
  );

  modport master (
    output DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA, SIZE_LOG2,
           CPU_A, CPU_CSB, DBG_REQ, DBG_A, ROM_DB,
    input  DL_WAIT, INIT_SEL, INIT_ADDR, INIT_DATA, INIT_VALID,
           CPU_DB, DBG_ACK, DBG_DB, ROM_A, ROM_CSB, SYS_RESET, OVERSIZE
  );
endinterface

// File: rtl/cart_rom_ctrl_arb.sv
// Run-time ROM read arbiter: CPU (mirrored, priority) versus debug reader.
// Latency: ROM_A combinational; CPU_DB follows ROM by 1 cycle; DBG_ACK 1 cycle after grant.
// Backpressure: debug waits while CPU selects or an ACK is outstanding (max 1 read / 2 cycles).
// Ports: CLK/RST; run (RUN state), grant_en (debug grants allowed), load_mask + size_log2
// (mirror mask capture); CPU, debug and ROM read buses.
module cart_rom_arb
  import scv_cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic              grant_en,
  input  logic              load_mask,
  input  logic [4:0]        size_log2,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic              cpu_csb,
  output logic [7:0]        cpu_db,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_a,
  output logic              dbg_ack,
  output logic [7:0]        dbg_db,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_csb,
  input  logic [7:0]        rom_db
);
  logic [ADDR_W-1:0] mask_r;
  logic              ack_q;
  logic [7:0]        dbg_db_q;
  logic              cpu_sel;
  logic              dbg_grant;

  // A SIZE_LOG2 of 0 marks a non-power-of-2 image: no mirroring.
  function automatic logic [ADDR_W-1:0] size_mask(input logic [4:0] l);
    if (l == 5'd0 || int'(l) >= ADDR_W) return '1;
    return ADDR_W'((32'd1 << l) - 32'd1);
  endfunction

  assign cpu_sel   = run && !cpu_csb;
  // No grant during the ACK cycle, so the captured data is never overwritten.
  assign dbg_grant = grant_en && cpu_csb && dbg_req && !ack_q;
  assign rom_csb   = !(cpu_sel || dbg_grant);
  assign rom_a     = cpu_sel   ? (cpu_a & mask_r) :
                     dbg_grant ? dbg_a : '0;
  assign cpu_db    = RST ? 8'h00 : (run ? rom_db : 8'hFF);
  assign dbg_ack   = ack_q;
  // Live ROM data in the ACK cycle, held value afterwards.
  assign dbg_db    = ack_q ? rom_db : dbg_db_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_r   <= '1;
      ack_q    <= 1'b0;
      dbg_db_q <= 8'h00;
    end else begin
      ack_q <= dbg_grant;
      if (ack_q)     dbg_db_q <= rom_db;
      if (load_mask) mask_r   <= size_mask(size_log2);
    end
  end
endmodule

// File: rtl/cart_rom_ctrl.sv
// Cartridge ROM load sequencer: download -> ROM init writes, system reset hold, then shared reads.
// Latency: INIT_VALID 1 cycle after DL_WR; SYS_RESET drops RESET_HOLD+2 cycles after INIT_SEL falls.
// Backpressure: DL_WAIT high in PAD/SETTLE/HOLD (DL_WR ignored); LOAD takes 1 byte/cycle.
// Optional feature macro: CART_PAD_FILL_EN (pads the image with PAD_BYTE up to a power of two).
// Ports: CLK, RST (sync, active-high), bus (cart_rom_ctrl_if.slave).
module cart_rom_ctrl
  import scv_cart_pkg::*;
#(
  parameter int ADDR_W     = CART_ADDR_W,
  parameter int RESET_HOLD = 16
`ifdef CART_PAD_FILL_EN
  , parameter logic [7:0] PAD_BYTE = CART_PAD_BYTE
`endif
) (
  input  logic            CLK,
  input  logic            RST,
  cart_rom_ctrl_if.slave  bus
);
  cart_state_t       state_q, state_d;
  logic [15:0]       cnt_q;
  logic              dl_active_q;
  logic              dl_rise;
  logic              oob;
  logic              wr_ok;
  logic              wr_oob;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] max_addr_q;
  logic              wrote_q;
  logic              oversize_q;
  logic              init_valid_q;
  logic [ADDR_W-1:0] init_addr_q;
  logic [7:0]        init_data_q;
  logic              settle_done;
  logic              hold_done;
`ifdef CART_PAD_FILL_EN
  logic [ADDR_W-1:0] pad_q;
  logic [ADDR_W-1:0] pad_end;

  assign pad_end = ADDR_W'(pad_end_of(24'(max_addr_q)));
`endif

  assign dl_rise     = bus.DL_ACTIVE & ~dl_active_q;
  assign oob         = |bus.DL_ADDR[23:ADDR_W];
  assign wr_addr     = bus.DL_ADDR[ADDR_W-1:0];
  assign wr_ok       = (state_q == ST_LOAD) && bus.DL_ACTIVE && bus.DL_WR && !oob;
  assign wr_oob      = (state_q == ST_LOAD) && bus.DL_ACTIVE && bus.DL_WR && oob;
  // SIZE_LOG2 is only valid on the second SETTLE cycle.
  assign settle_done = (state_q == ST_SETTLE) && (cnt_q == 16'd1);
  assign hold_done   = (state_q == ST_HOLD) && (cnt_q == 16'(RESET_HOLD - 1));

  // Sampled even during reset so a download still active across RST is not
  // seen as a fresh rising edge afterwards.
  always_ff @(posedge CLK) dl_active_q <= bus.DL_ACTIVE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (dl_rise) state_d = ST_LOAD;
      ST_LOAD: begin
        // Any INIT_VALID from the last byte is on the bus this cycle, so
        // leaving now still lets it land with INIT_SEL high.
        if (!bus.DL_ACTIVE) begin
          if (!wrote_q) state_d = ST_EMPTY;
`ifdef CART_PAD_FILL_EN
          else          state_d = ST_PAD;
`else
          else          state_d = ST_SETTLE;
`endif
        end
      end
`ifdef CART_PAD_FILL_EN
      ST_PAD:    if (pad_q == pad_end) state_d = ST_SETTLE;
`else
      ST_PAD:    state_d = ST_SETTLE;
`endif
      ST_SETTLE: if (settle_done) state_d = ST_HOLD;
      ST_HOLD: begin
        if (dl_rise)        state_d = ST_LOAD;
        else if (hold_done) state_d = ST_RUN;
      end
      ST_RUN:   if (dl_rise) state_d = ST_LOAD;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_EMPTY;
      cnt_q        <= 16'd0;
      max_addr_q   <= '0;
      wrote_q      <= 1'b0;
      oversize_q   <= 1'b0;
      init_valid_q <= 1'b0;
      init_addr_q  <= '0;
      init_data_q  <= 8'h00;
`ifdef CART_PAD_FILL_EN
      pad_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      init_valid_q <= 1'b0;
      if (dl_rise && state_d == ST_LOAD) begin
        oversize_q <= 1'b0;
        max_addr_q <= '0;
        wrote_q    <= 1'b0;
      end
      if (wr_ok) begin
        init_valid_q <= 1'b1;
        init_addr_q  <= wr_addr;
        init_data_q  <= bus.DL_DATA;
        wrote_q      <= 1'b1;
        if (wr_addr > max_addr_q) max_addr_q <= wr_addr;
      end
      if (wr_oob) oversize_q <= 1'b1;
`ifdef CART_PAD_FILL_EN
      // pad_q is the last address already written; each PAD cycle writes the next one.
      if (state_q == ST_LOAD && state_d == ST_PAD) begin
        pad_q <= max_addr_q;
      end else if (state_q == ST_PAD && pad_q != pad_end) begin
        pad_q        <= pad_q + 1'b1;
        init_valid_q <= 1'b1;
        init_addr_q  <= pad_q + 1'b1;
        init_data_q  <= PAD_BYTE;
      end
`endif
    end
  end

  assign bus.DL_WAIT    = (state_q == ST_PAD) || (state_q == ST_SETTLE) || (state_q == ST_HOLD);
  assign bus.INIT_SEL   = (state_q == ST_LOAD) || (state_q == ST_PAD);
  assign bus.INIT_VALID = init_valid_q;
  assign bus.INIT_ADDR  = init_addr_q;
  assign bus.INIT_DATA  = init_data_q;
  assign bus.SYS_RESET  = (state_q != ST_RUN);
  assign bus.OVERSIZE   = oversize_q;

  cart_rom_arb #(.ADDR_W(ADDR_W)) u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .run       (state_q == ST_RUN),
    .grant_en  ((state_q == ST_RUN) && !dl_rise),
    .load_mask (settle_done),
    .size_log2 (bus.SIZE_LOG2),
    .cpu_a     (bus.CPU_A),
    .cpu_csb   (bus.CPU_CSB),
    .cpu_db    (bus.CPU_DB),
    .dbg_req   (bus.DBG_REQ),
    .dbg_a     (bus.DBG_A),
    .dbg_ack   (bus.DBG_ACK),
    .dbg_db    (bus.DBG_DB),
    .rom_a     (bus.ROM_A),
    .rom_csb   (bus.ROM_CSB),
    .rom_db    (bus.ROM_DB)
  );
endmodule
